calc_operand_seq: RTL

Upstream sequencer for the 8-bit add/sub calculator core (`top`: num1, num2, sel -> out, flowIndicator).
- Accepts a byte stream over a valid/ready handshake, in the order operand A, operand B, opcode byte.
- Drives the core's operands from registers and captures the core's combinational result one cycle later.
- Presents the result downstream on a second valid/ready handshake.
- Keeps a saturating count of overflow results.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_operand_seq_sat_counter.sv | 28 ++
 rtl/calc_operand_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand sequencer.
//   state_t  : sequencer FSM states (3-bit encoding)
//   SEL_ADD / SEL_SUB : core opcode values on calc_sel
//   CALC_W   : default operand/result width of the add/sub core
package calc_pkg;

  localparam int CALC_W = 8;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/calc_operand_seq_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current count value
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/calc_operand_seq.sv
// Upstream sequencer for the 8-bit add/sub calculator core.
// Collects operand A, operand B and an opcode byte over a valid/ready
// stream, drives the core from registers, captures the core's result one
// cycle later and offers it downstream on a second valid/ready handshake.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_data/valid/ready  : byte stream in (A, B, opcode; opcode bit0 = sel)
//   calc_num1/num2/sel   : registered operands to the core
//   calc_out/calc_flow   : combinational result and carry/borrow from core
//   res_data/flow/valid/ready : captured result out
//   flow_count           : saturating count of results with flow set
//   busy                 : high whenever not waiting for operand A
module calc_operand_seq
  import calc_pkg::*;
#(
  parameter int W     = CALC_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     calc_num1,
  output logic [W-1:0]     calc_num2,
  output logic             calc_sel,
  input  logic [W-1:0]     calc_out,
  input  logic             calc_flow,
  output logic [W-1:0]     res_data,
  output logic             res_flow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] flow_count,
  output logic             busy
);

  state_t       r_state;
  logic [W-1:0] r_num1;
  logic [W-1:0] r_num2;
  logic         r_sel;
  logic [W-1:0] r_res_data;
  logic         r_res_flow;
  logic         r_res_valid;
  logic         w_in_ready;
  logic         w_flow_inc;

  // Input is accepted only while collecting bytes; decoded straight from
  // the state register so it is glitch-free.
  assign w_in_ready = (r_state == GET_A) || (r_state == GET_B) ||
                      (r_state == GET_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= GET_A;
      r_num1      <= '0;
      r_num2      <= '0;
      r_sel       <= SEL_ADD;
      r_res_data  <= '0;
      r_res_flow  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        GET_A: begin
          if (in_valid) begin
            r_num1  <= in_data;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (in_valid) begin
            r_num2  <= in_data;
            r_state <= GET_OP;
          end
        end
        GET_OP: begin
          if (in_valid) begin
            r_sel   <= in_data[0];
            r_state <= EXEC;
          end
        end
        EXEC: begin
          // Operands have been stable for a full cycle, so the core's
          // combinational output is settled here.
          r_res_data  <= calc_out;
          r_res_flow  <= calc_flow;
          r_res_valid <= 1'b1;
          r_state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= GET_A;
          end
        end
        default: begin
          r_state <= GET_A;
        end
      endcase
    end
  end

  // Count overflow at capture time so a stalled consumer cannot delay or
  // duplicate the event.
  assign w_flow_inc = (r_state == EXEC) && calc_flow;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flow_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flow_inc),
    .count (flow_count)
  );

  assign in_ready  = w_in_ready;
  assign calc_num1 = r_num1;
  assign calc_num2 = r_num2;
  assign calc_sel  = r_sel;
  assign res_data  = r_res_data;
  assign res_flow  = r_res_flow;
  assign res_valid = r_res_valid;
  assign busy      = (r_state != GET_A);

endmodule
